// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_kbd_pkg;

  localparam logic [7:0] PS2_E0 = 8'hE0;
  localparam logic [7:0] PS2_F0 = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GOT_E0,
    ST_GOT_F0,
    ST_GOT_E0F0
  } dec_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kbd_evt_t;

endpackage

// File: rtl/ps2_kbd_fifo.sv
// Synchronous event FIFO, registered head (no fall-through); drop flagged when full.
module ps2_kbd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             full, pop_ok, push_ok;

  always_comb begin
    full     = (level_q == (AW+1)'(DEPTH));
    pop_ok   = pop && (level_q != '0);
    // A write into a full FIFO is allowed when the head leaves in the same cycle.
    push_ok  = push && (!full || pop_ok);
    drop     = push && full && !pop_ok;
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push_ok && !pop_ok) level_d = level_q + (AW+1)'(1);
    else if (!push_ok && pop_ok) level_d = level_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign valid = (level_q != '0);
  assign level = level_q;
  assign dout  = valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: frame capture, E0/F0 decoder, event FIFO.
// Optional press counter output enabled by defining PS2_KBD_PRESS_CNT_EN.
module ps2_kbd_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [9:0]                    out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [7:0]                    frame_err_cnt
`ifdef PS2_KBD_PRESS_CNT_EN
  ,
  output logic [15:0]                   press_cnt
`endif
);

  import ps2_kbd_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [9:0]             shift_q, shift_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   frame_ok_q, frame_ok_d;
  logic                   frame_bad_q, frame_bad_d;
  logic [7:0]             byte_q, byte_d;
  logic [7:0]             err_cnt_q, err_cnt_d;
  logic                   overflow_q, overflow_d;
  dec_state_e             state_q, state_d;

  logic                   fall, sample, timeout, frame_good;
  kbd_evt_t               evt;
  logic                   evt_push, fifo_drop;

  // Frame capture: bits shift in from the top so the start bit ends at shift_q[0].
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    dat_sync_d  = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
    fall        = clk_sync_q[SYNC_STAGES-1] & ~clk_sync_q[SYNC_STAGES-2];
    sample      = dat_sync_q[SYNC_STAGES-1];
    timeout     = (bit_cnt_q != '0) && !fall && (timer_q == TW'(TIMEOUT_CYCLES - 1));
    frame_good  = !shift_q[0] && sample && (^shift_q[9:1]);
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_d      = byte_q;
    frame_ok_d  = 1'b0;
    frame_bad_d = 1'b0;
    if (fall) begin
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d   = '0;
        frame_ok_d  = frame_good;
        frame_bad_d = !frame_good;
        byte_d      = shift_q[8:1];
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        shift_d   = {sample, shift_q[9:1]};
      end
    end else if (timeout) begin
      bit_cnt_d = '0;
    end
    timer_d = (fall || bit_cnt_q == '0 || timeout) ? '0 : timer_q + TW'(1);
  end

  // Decoder runs one clock after the stop-bit strobe, on the registered byte.
  always_comb begin
    state_d  = state_q;
    evt      = '0;
    evt_push = 1'b0;
    if (frame_bad_q || timeout) begin
      state_d = ST_IDLE;
    end else if (frame_ok_q) begin
      if (byte_q == PS2_E0) begin
        state_d = ST_GOT_E0;
      end else if (byte_q == PS2_F0 && state_q == ST_IDLE) begin
        state_d = ST_GOT_F0;
      end else if (byte_q == PS2_F0 && state_q == ST_GOT_E0) begin
        state_d = ST_GOT_E0F0;
      end else begin
        evt.ext  = (state_q == ST_GOT_E0) || (state_q == ST_GOT_E0F0);
        evt.brk  = (state_q == ST_GOT_F0) || (state_q == ST_GOT_E0F0);
        evt.code = byte_q;
        evt_push = 1'b1;
        state_d  = ST_IDLE;
      end
    end
  end

  always_comb begin
    err_cnt_d  = err_cnt_q;
    if ((frame_bad_q || timeout) && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    overflow_d = overflow_q | fifo_drop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q  <= '1;
      dat_sync_q  <= '1;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      timer_q     <= '0;
      frame_ok_q  <= 1'b0;
      frame_bad_q <= 1'b0;
      byte_q      <= '0;
      err_cnt_q   <= '0;
      overflow_q  <= 1'b0;
      state_q     <= ST_IDLE;
    end else begin
      clk_sync_q  <= clk_sync_d;
      dat_sync_q  <= dat_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      timer_q     <= timer_d;
      frame_ok_q  <= frame_ok_d;
      frame_bad_q <= frame_bad_d;
      byte_q      <= byte_d;
      err_cnt_q   <= err_cnt_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
    end
  end

  ps2_kbd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (10)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (evt_push),
    .din   (evt),
    .pop   (out_ready),
    .dout  (out_data),
    .valid (out_valid),
    .level (fifo_level),
    .drop  (fifo_drop)
  );

  assign overflow      = overflow_q;
  assign frame_err_cnt = err_cnt_q;

`ifdef PS2_KBD_PRESS_CNT_EN
  logic [15:0] press_cnt_q, press_cnt_d;

  always_comb begin
    press_cnt_d = press_cnt_q;
    if (evt_push && !fifo_drop && !evt.brk) press_cnt_d = press_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) press_cnt_q <= '0;
    else      press_cnt_q <= press_cnt_d;
  end

  assign press_cnt = press_cnt_q;
`endif

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: drives PS/2 frames and checks decoded events.
module tb_ps2_kbd_rx;

  localparam int FIFO_DEPTH     = 8;
  localparam int SYNC_STAGES    = 3;
  localparam int TIMEOUT_CYCLES = 200;
  localparam int H              = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_data;
  logic [3:0] fifo_level;
  logic       overflow;
  logic [7:0] frame_err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ps2_kbd_rx #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ps2_clk       (ps2_clk),
    .ps2_data      (ps2_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .fifo_level    (fifo_level),
    .overflow      (overflow),
    .frame_err_cnt (frame_err_cnt)
  );

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad);
    logic p;
    p = ~^b;
    if (bad) p = ~p;
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      idle(H);
      ps2_clk = 1'b0;
      idle(H);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(mk_frame(b, 1'b0), 11);
    idle(H);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle(4);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++; if (out_data !== 10'h000) begin n_fail++; $display("FAIL reset_data: got %h want 000", out_data); end
    n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_checks++; if (frame_err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_errcnt: got %0d want 0", frame_err_cnt); end
    rst = 1'b1;
    idle(4);
  endtask

  task automatic test_single_make();
    send_bits(mk_frame(8'h1C, 1'b0), 10);
    @(negedge clk);
    ps2_data = 1'b1;
    idle(H);
    ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early: out_valid got %b want 0", out_valid); end
    @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_rise: out_valid got %b want 1", out_valid); end
    idle(H);
    ps2_clk = 1'b1;
    idle(H);
    n_checks++; if (out_data !== 10'h01C) begin n_fail++; $display("FAIL make_data: got %h want 01C", out_data); end
    n_checks++; if (fifo_level !== 4'd1) begin n_fail++; $display("FAIL make_level: got %0d want 1", fifo_level); end
    pop_one();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL make_pop: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_break();
    send_byte(8'hF0);
    n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL brk_prefix: level got %0d want 0", fifo_level); end
    send_byte(8'h1C);
    n_checks++; if (fifo_level !== 4'd1) begin n_fail++; $display("FAIL brk_level: got %0d want 1", fifo_level); end
    n_checks++; if (out_data !== 10'h11C) begin n_fail++; $display("FAIL brk_data: got %h want 11C", out_data); end
    pop_one();
  endtask

  task automatic test_ext();
    send_byte(8'hE0);
    send_byte(8'hF0);
    n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL ext_prefix: level got %0d want 0", fifo_level); end
    send_byte(8'h75);
    n_checks++; if (fifo_level !== 4'd1) begin n_fail++; $display("FAIL extbrk_level: got %0d want 1", fifo_level); end
    n_checks++; if (out_data !== 10'h375) begin n_fail++; $display("FAIL extbrk_data: got %h want 375", out_data); end
    pop_one();
    send_byte(8'hE0);
    send_byte(8'h75);
    n_checks++; if (out_data !== 10'h275) begin n_fail++; $display("FAIL ext_data: got %h want 275", out_data); end
    pop_one();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ext_empty: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_parity_err();
    send_bits(mk_frame(8'h1C, 1'b1), 11);
    idle(H);
    n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL par_noevt: level got %0d want 0", fifo_level); end
    n_checks++; if (frame_err_cnt !== 8'd1) begin n_fail++; $display("FAIL par_errcnt: got %0d want 1", frame_err_cnt); end
    send_byte(8'h32);
    n_checks++; if (out_data !== 10'h032) begin n_fail++; $display("FAIL par_next: got %h want 032", out_data); end
    n_checks++; if (frame_err_cnt !== 8'd1) begin n_fail++; $display("FAIL par_errhold: got %0d want 1", frame_err_cnt); end
    pop_one();
  endtask

  task automatic test_overflow();
    logic [7:0] code;
    for (int i = 0; i < 9; i++) begin
      code = 8'h15 + 8'(i);
      send_byte(code);
    end
    n_checks++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL ovf_level: got %0d want 8", fifo_level); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    idle(3);
    n_checks++; if (out_data !== 10'h015) begin n_fail++; $display("FAIL ovf_hold: got %h want 015", out_data); end
    for (int i = 0; i < 8; i++) begin
      code = 8'h15 + 8'(i);
      n_checks++;
      if (out_data !== {2'b00, code}) begin
        n_fail++;
        $display("FAIL ovf_drain[%0d]: got %h want %h", i, out_data, {2'b00, code});
      end
      pop_one();
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: out_valid got %b want 0", out_valid); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_timeout();
    send_bits(mk_frame(8'h2B, 1'b0), 5);
    idle(TIMEOUT_CYCLES + 60);
    n_checks++; if (frame_err_cnt !== 8'd2) begin n_fail++; $display("FAIL to_errcnt: got %0d want 2", frame_err_cnt); end
    n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL to_noevt: level got %0d want 0", fifo_level); end
    send_byte(8'h2B);
    n_checks++; if (out_data !== 10'h02B) begin n_fail++; $display("FAIL to_next: got %h want 02B", out_data); end
    n_checks++; if (frame_err_cnt !== 8'd2) begin n_fail++; $display("FAIL to_errhold: got %0d want 2", frame_err_cnt); end
    pop_one();
  endtask

  task automatic test_mid_reset();
    send_byte(8'h33);
    send_bits(mk_frame(8'h44, 1'b0), 4);
    rst = 1'b0;
    idle(3);
    n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL mr_level: got %0d want 0", fifo_level); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_valid: got %b want 0", out_valid); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mr_overflow: got %b want 0", overflow); end
    n_checks++; if (frame_err_cnt !== 8'd0) begin n_fail++; $display("FAIL mr_errcnt: got %0d want 0", frame_err_cnt); end
    rst = 1'b1;
    idle(5);
    send_byte(8'h1C);
    n_checks++; if (fifo_level !== 4'd1) begin n_fail++; $display("FAIL mr_next_level: got %0d want 1", fifo_level); end
    n_checks++; if (out_data !== 10'h01C) begin n_fail++; $display("FAIL mr_next_data: got %h want 01C", out_data); end
    n_checks++; if (frame_err_cnt !== 8'd0) begin n_fail++; $display("FAIL mr_next_err: got %0d want 0", frame_err_cnt); end
    pop_one();
  endtask

  initial begin
    rst       = 1'b0;
    ps2_clk   = 1'b1;
    ps2_data  = 1'b1;
    out_ready = 1'b0;
    test_reset();
    test_single_make();
    test_break();
    test_ext();
    test_parity_err();
    test_overflow();
    test_timeout();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
